// File: rtl/partida_turnos_ctrl.sv
// Match scheduler for the two-player chess-square drill: alternates turns, runs the
// per-turn countdown, scores hits and closes the match after N_RODADAS rounds or on abort.
module partida_turnos_ctrl #(
  parameter int N_RODADAS = 8,
  parameter int T_TURNO   = 50,
  parameter int W_PONTOS  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                terminar,
  input  logic                tick,
  input  logic                geradaOk,
  input  logic                temJogada,
  input  logic                acertou,
  output logic                geraNova,
  output logic                registraR,
  output logic                zeraR,
  output logic                jogador,
  output logic [W_PONTOS-1:0] pontos1,
  output logic [W_PONTOS-1:0] pontos2,
  output logic [3:0]          rodada,
  output logic [7:0]          tempo,
  output logic                fimPartida,
  output logic [1:0]          vencedor,
  output logic [3:0]          db_estado
);

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    PREPARA = 4'd1,
    GERA    = 4'd2,
    ESPERA  = 4'd3,
    AVALIA  = 4'd4,
    TROCA   = 4'd5,
    FIM     = 4'd6
  } estado_t;

  estado_t    estado, proxEstado;
  logic       ativo;
  logic       limpa, carregaTempo, decTempo, expiraTempo, pontua, troca;
  logic [3:0] rodadaProx;

  // Handshakes: geraNova is a level request held for the whole GERA stay and
  // dropped the cycle after geradaOk; registraR and zeraR are single-cycle strobes.
  assign rodadaProx = jogador ? rodada + 4'd1 : rodada;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= proxEstado;
  end

  always_comb begin
    proxEstado   = estado;
    ativo        = 1'b0;
    limpa        = 1'b0;
    carregaTempo = 1'b0;
    decTempo     = 1'b0;
    expiraTempo  = 1'b0;
    pontua       = 1'b0;
    troca        = 1'b0;
    geraNova     = 1'b0;
    registraR    = 1'b0;
    zeraR        = 1'b0;
    case (estado)
      OCIOSO: if (iniciar) proxEstado = PREPARA;
      PREPARA: begin
        ativo      = 1'b1;
        zeraR      = 1'b1;
        limpa      = 1'b1;
        proxEstado = GERA;
      end
      GERA: begin
        ativo    = 1'b1;
        geraNova = 1'b1;
        if (geradaOk) begin
          carregaTempo = 1'b1;
          proxEstado   = ESPERA;
        end
      end
      ESPERA: begin
        ativo = 1'b1;
        if (temJogada) begin
          registraR  = 1'b1;
          proxEstado = AVALIA;
        end else if (tick) begin
          if (tempo > 8'd1) begin
            decTempo = 1'b1;
          end else begin
            expiraTempo = 1'b1;
            proxEstado  = TROCA;
          end
        end
      end
      AVALIA: begin
        ativo      = 1'b1;
        zeraR      = 1'b1;
        pontua     = acertou;
        proxEstado = TROCA;
      end
      TROCA: begin
        ativo      = 1'b1;
        troca      = 1'b1;
        proxEstado = (rodadaProx == 4'(N_RODADAS)) ? FIM : GERA;
      end
      FIM: if (iniciar) proxEstado = PREPARA;
      default: proxEstado = OCIOSO;
    endcase
    // Abort wins over everything: no move latched, no point, no counter update.
    if (ativo && terminar) begin
      proxEstado   = FIM;
      limpa        = 1'b0;
      carregaTempo = 1'b0;
      decTempo     = 1'b0;
      expiraTempo  = 1'b0;
      pontua       = 1'b0;
      troca        = 1'b0;
      registraR    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jogador <= 1'b0;
      pontos1 <= '0;
      pontos2 <= '0;
      rodada  <= 4'd0;
      tempo   <= 8'd0;
    end else begin
      if (limpa) begin
        jogador <= 1'b0;
        pontos1 <= '0;
        pontos2 <= '0;
        rodada  <= 4'd0;
      end
      if (carregaTempo)     tempo <= 8'(T_TURNO);
      else if (decTempo)    tempo <= tempo - 8'd1;
      else if (expiraTempo) tempo <= 8'd0;
      if (pontua) begin
        if (!jogador && pontos1 != '1) pontos1 <= pontos1 + W_PONTOS'(1);
        if (jogador && pontos2 != '1)  pontos2 <= pontos2 + W_PONTOS'(1);
      end
      if (troca) begin
        jogador <= ~jogador;
        rodada  <= rodadaProx;
      end
    end
  end

  always_comb begin
    vencedor = 2'b00;
    if (estado == FIM) begin
      if (pontos1 > pontos2)      vencedor = 2'b01;
      else if (pontos2 > pontos1) vencedor = 2'b10;
      else                        vencedor = 2'b11;
    end
  end

  assign fimPartida = (estado == FIM);
  assign db_estado  = estado;

endmodule
